commit_trace: RTL
=================

COMMIT_TRACE -- requirements
Module: commit_trace

Interface
REQ-001 SHALL have parameter DEPTH, default 8, FIFO entry count; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port wb_pc  input  64  PC of the instruction in WB; 0 means bubble.
REQ-005 SHALL have port wb_rf_we  input  8  replicated register-write enable; only bit 0 is used.
REQ-006 SHALL have port wb_rf_wnum  input  5  destination register number.
REQ-007 SHALL have port wb_rf_wdata  input  64  register write data.
REQ-008 SHALL have port stat_clr  input  1  one-cycle pulse that clears the statistics.
REQ-009 SHALL have ports trace_valid  output  1  and trace_ready  input  1  as the drain handshake.
REQ-010 SHALL have trace outputs trace_pc  output  64, trace_we  output  1, trace_wnum  output  5, trace_wdata  output  64, trace_seq  output  32; together these form the head entry.
REQ-011 SHALL have status outputs commit_cnt  output  64, drop_cnt  output  32, overflow  output  1, level  output  log2(DEPTH)+1.

Function
REQ-012 A cycle SHALL be a commit when wb_pc != 0; cycles with wb_pc == 0 SHALL be ignored entirely.
REQ-013 Each commit SHALL form an entry {pc, we, wnum, wdata, seq}, with we = wb_rf_we[0] & (wb_rf_wnum != 0).
REQ-014 When the entry's we is 0, its wnum and wdata SHALL both be forced to 0.
REQ-015 seq SHALL be a 32-bit counter that increments on every commit, whether accepted or dropped, and wraps from FFFFFFFF to 0; each entry carries the pre-increment value.
REQ-016 A push SHALL be written into the FIFO at the clock edge of the commit; trace_valid SHALL rise on the next cycle (latency 1, no fall-through).
REQ-017 A pop SHALL occur when trace_valid & trace_ready; the head fields SHALL remain stable while trace_valid & !trace_ready.
REQ-018 A push and a pop in the same cycle SHALL both take effect, including when the FIFO is full; level is then unchanged.
REQ-019 A push into a full FIFO with no pop SHALL be discarded; drop_cnt SHALL increment (saturating at FFFFFFFF) and overflow SHALL set and remain set.
REQ-020 commit_cnt SHALL increment on every commit, wrapping at 2^64.
REQ-021 When stat_clr is high, commit_cnt, drop_cnt and overflow SHALL become 0 on the next edge; stat_clr SHALL take priority over a same-cycle increment; FIFO contents and seq SHALL be unaffected.
REQ-022 level SHALL equal the number of valid entries (0..DEPTH); trace_valid SHALL equal (level != 0).
REQ-023 Read and write pointers SHALL wrap modulo DEPTH; full and empty SHALL be distinguished by an extra pointer bit or by the level count.

Reset
REQ-024 While rst_n == 0 at a clock edge: pointers, level, seq, commit_cnt, drop_cnt and overflow SHALL go to 0, and trace_valid SHALL be 0.
REQ-025 Reset SHALL win over any same-cycle commit or pop; entries in flight SHALL be lost; trace data outputs are don't-care while trace_valid == 0.

Structure
REQ-026 Entry field widths (64/1/5/64/32), the packed entry width of 166, and the default DEPTH SHALL be defined as constants in the shared define.v header.
REQ-027 Storage SHALL be a sub-module trace_fifo: synchronous FIFO, parameterised width and depth, with push, pop, full, empty and level; commit_trace holds the entry formation, seq and the statistics.
REQ-028 The design SHALL contain no combinational path from wb_* inputs to any trace_* output.

Verification
REQ-029 Reset, then 3 commits with pc = 0x80000000, 0x80000004, 0x80000008 (we = FF, wnum = 5, wdata = 0x11), trace_ready = 1 -> 3 entries with seq 0, 1, 2, each appearing one cycle after its commit; commit_cnt = 3, level returns to 0.
REQ-030 Commit with wnum = 0, we = FF, wdata = 0xDEAD -> entry has we = 0, wnum = 0, wdata = 0.
REQ-031 With trace_ready = 0, issue 10 back-to-back commits (DEPTH = 8) -> level = 8, drop_cnt = 2, overflow = 1; then drain with seq 0..7; the next commit gets seq 10.
REQ-032 With the FIFO full, trace_ready = 1 and a commit in the same cycle -> no drop, level stays 8, head advances by one.
REQ-033 Interleave wb_pc = 0 bubbles, and hold trace_ready = 0 for 4 cycles mid-stream -> bubbles produce no entries and the head fields stay constant while stalled.
REQ-034 stat_clr asserted in the same cycle as a commit, with commit_cnt = 5 beforehand -> commit_cnt = 0 and overflow = 0, while the entry is still pushed with the correct seq; separately, rst_n = 0 with level = 4 -> level 0 and trace_valid 0 on the next cycle.

Source files
------------

// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg
//   Shared constants and types for the commit trace buffer.
//   - Field widths of one trace entry: pc 64, we 1, wnum 5, wdata 64, seq 32.
//   - ENTRY_W is the packed entry width (166 bits).
//   - DEFAULT_DEPTH is the default FIFO entry count.
//   - trace_entry_t is the packed entry layout {pc, we, wnum, wdata, seq}.
//   - make_entry() builds an entry from raw write-back signals.
package commit_trace_pkg;

  localparam int PC_W          = 64;
  localparam int WE_W          = 1;
  localparam int WNUM_W        = 5;
  localparam int WDATA_W       = 64;
  localparam int SEQ_W         = 32;
  localparam int ENTRY_W       = PC_W + WE_W + WNUM_W + WDATA_W + SEQ_W;
  localparam int DEFAULT_DEPTH = 8;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic               we;
    logic [WNUM_W-1:0]  wnum;
    logic [WDATA_W-1:0] wdata;
    logic [SEQ_W-1:0]   seq;
  } trace_entry_t;

  // Writes to x0 are not real register writes, and a non-writing entry
  // carries zeroed wnum/wdata so trace consumers see a canonical form.
  function automatic trace_entry_t make_entry(
    input logic [PC_W-1:0]    pc,
    input logic               rf_we,
    input logic [WNUM_W-1:0]  wnum,
    input logic [WDATA_W-1:0] wdata,
    input logic [SEQ_W-1:0]   seq
  );
    trace_entry_t e;
    e.pc    = pc;
    e.we    = rf_we & (wnum != '0);
    e.wnum  = e.we ? wnum  : '0;
    e.wdata = e.we ? wdata : '0;
    e.seq   = seq;
    return e;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// trace_fifo
//   Synchronous FIFO with registered state and an unregistered head read
//   (the head is the storage word at the read pointer, so data appears the
//   cycle after it is written; there is no fall-through path).
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     push, push_data write request and data
//     pop             read request (ignored when empty)
//     pop_data        head entry
//     full, empty     occupancy flags
//     level           number of valid entries, 0..DEPTH
//   A push into a full FIFO is accepted only when a pop happens in the same
//   cycle; the freed slot is the one being written.
module trace_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q,  level_d;
  logic          do_push, do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == FULL_LEVEL);
  assign level = level_q;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Pointers are AW bits wide and DEPTH is a power of two, so the natural
  // overflow of the increment is the modulo-DEPTH wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({do_push, do_pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage has no reset: stale words are never visible because the
  // level count gates validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign pop_data = mem[rd_ptr_q];

endmodule

// File: rtl/commit_trace.sv
// commit_trace
//   Captures every retired instruction from the write-back stage into a
//   trace FIFO and keeps commit statistics.
//   Ports:
//     clk, rst_n           clock, synchronous active-low reset
//     wb_pc                PC in WB, 0 = bubble (no commit)
//     wb_rf_we             replicated register write enable, bit 0 used
//     wb_rf_wnum/wb_rf_wdata destination register and write data
//     stat_clr             pulse clearing commit_cnt, drop_cnt, overflow
//     trace_valid/ready    drain handshake for the head entry
//     trace_pc/we/wnum/wdata/seq  head entry fields
//     commit_cnt           total commits (wraps at 2^64)
//     drop_cnt             commits lost to a full FIFO (saturating)
//     overflow             sticky: at least one commit was dropped
//     level                FIFO occupancy, 0..DEPTH
//   All trace_* outputs come from registered FIFO state, so there is no
//   combinational path from wb_* to the trace side.
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [63:0]              wb_pc,
  input  logic [7:0]               wb_rf_we,
  input  logic [4:0]               wb_rf_wnum,
  input  logic [63:0]              wb_rf_wdata,
  input  logic                     stat_clr,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [63:0]              trace_pc,
  output logic                     trace_we,
  output logic [4:0]               trace_wnum,
  output logic [63:0]              trace_wdata,
  output logic [31:0]              trace_seq,
  output logic [63:0]              commit_cnt,
  output logic [31:0]              drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   level
);

  logic [SEQ_W-1:0] seq_q,        seq_d;
  logic [63:0]      commit_cnt_q, commit_cnt_d;
  logic [31:0]      drop_cnt_q,   drop_cnt_d;
  logic             overflow_q,   overflow_d;

  logic         commit;
  logic         pop;
  logic         drop;
  logic         fifo_full;
  logic         fifo_empty;
  trace_entry_t new_entry;
  trace_entry_t head_entry;

  // Only bit 0 of the replicated enable carries information.
  logic unused_we_bits;
  assign unused_we_bits = ^wb_rf_we[7:1];

  assign commit    = (wb_pc != '0);
  assign new_entry = make_entry(wb_pc, wb_rf_we[0], wb_rf_wnum, wb_rf_wdata, seq_q);
  assign pop       = trace_valid & trace_ready;
  // A full FIFO still accepts the commit when the head leaves this cycle.
  assign drop      = commit & fifo_full & ~pop;

  trace_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (commit),
    .push_data (new_entry),
    .pop       (pop),
    .pop_data  (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign trace_valid = ~fifo_empty;
  assign trace_pc    = head_entry.pc;
  assign trace_we    = head_entry.we;
  assign trace_wnum  = head_entry.wnum;
  assign trace_wdata = head_entry.wdata;
  assign trace_seq   = head_entry.seq;

  // seq counts every commit, dropped or not, so gaps in the drained
  // sequence numbers reveal exactly which commits were lost.
  always_comb begin
    seq_d        = seq_q + SEQ_W'(commit);
    commit_cnt_d = commit_cnt_q + 64'(commit);
    drop_cnt_d   = drop_cnt_q;
    overflow_d   = overflow_q | drop;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
    // Clearing beats a same-cycle increment; seq is deliberately untouched.
    if (stat_clr) begin
      commit_cnt_d = '0;
      drop_cnt_d   = '0;
      overflow_d   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_q        <= '0;
      commit_cnt_q <= '0;
      drop_cnt_q   <= '0;
      overflow_q   <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      commit_cnt_q <= commit_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      overflow_q   <= overflow_d;
    end
  end

  assign commit_cnt = commit_cnt_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

endmodule
